// File: rtl/gate_id_pkg.sv
// Shared definitions for the 2-input gate truth-table analyzer.
// Holds the gate code values, the 4-bit truth-table signature of each gate
// (tt[i] = y for (a,b) = (i[1],i[0])) and the sweep FSM state encoding.
package gate_id_pkg;

    localparam int unsigned TT_W      = 4;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned VEC_COUNT = 4;

    localparam logic [CODE_W-1:0] GATE_AND     = 3'd0;
    localparam logic [CODE_W-1:0] GATE_OR      = 3'd1;
    localparam logic [CODE_W-1:0] GATE_NOT_A   = 3'd2;
    localparam logic [CODE_W-1:0] GATE_NAND    = 3'd3;
    localparam logic [CODE_W-1:0] GATE_NOR     = 3'd4;
    localparam logic [CODE_W-1:0] GATE_XOR     = 3'd5;
    localparam logic [CODE_W-1:0] GATE_XNOR    = 3'd6;
    localparam logic [CODE_W-1:0] GATE_UNKNOWN = 3'd7;

    localparam logic [TT_W-1:0] TT_AND   = 4'b1000;
    localparam logic [TT_W-1:0] TT_OR    = 4'b1110;
    localparam logic [TT_W-1:0] TT_NOT_A = 4'b0011;
    localparam logic [TT_W-1:0] TT_NAND  = 4'b0111;
    localparam logic [TT_W-1:0] TT_NOR   = 4'b0001;
    localparam logic [TT_W-1:0] TT_XOR   = 4'b0110;
    localparam logic [TT_W-1:0] TT_XNOR  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/gate_classifier.sv
// Combinational decoder from a captured 4-entry truth table to a gate code.
// Ports:
//   tt      in  4  truth table, tt[i] = y for (a,b) = (i[1],i[0])
//   code_c  out 3  gate code, GATE_UNKNOWN for any unrecognised pattern
//   match_c out 1  high when the pattern is one of the known gates
module gate_classifier
    import gate_id_pkg::*;
(
    input  logic [TT_W-1:0]   tt,
    output logic [CODE_W-1:0] code_c,
    output logic              match_c
);

    // Constant, NOT_B and all other patterns fall through to unknown.
    always_comb begin
        code_c = GATE_UNKNOWN;
        case (tt)
            TT_AND:   code_c = GATE_AND;
            TT_OR:    code_c = GATE_OR;
            TT_NOT_A: code_c = GATE_NOT_A;
            TT_NAND:  code_c = GATE_NAND;
            TT_NOR:   code_c = GATE_NOR;
            TT_XOR:   code_c = GATE_XOR;
            TT_XNOR:  code_c = GATE_XNOR;
            default:  code_c = GATE_UNKNOWN;
        endcase
        match_c = (code_c != GATE_UNKNOWN);
    end

endmodule

// File: rtl/gate_truth_table_analyzer.sv
// Drives the four operand combinations into a 2-input gate under test,
// samples its output after a settle interval, builds the truth table and
// classifies the gate.
// Ports:
//   clk          in   1  clock, all state on rising edge
//   rst          in   1  synchronous active-high reset
//   start        in   1  sweep request, honoured only in IDLE
//   y_in         in   1  gate-under-test output (synchronous to clk)
//   a_out, b_out out  1  operands driven to the gate under test
//   busy         out  1  sweep/classify in progress
//   done         out  1  one-cycle pulse, results valid
//   truth_table  out  4  captured table, held until the next done
//   gate_code    out  3  decoded gate, 7 = unknown
//   match        out  1  gate_code is a known gate
module gate_truth_table_analyzer
    import gate_id_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y_in,
    output logic              a_out,
    output logic              b_out,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   truth_table,
    output logic [CODE_W-1:0] gate_code,
    output logic              match
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_COUNT - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [TT_W-1:0]   tt_q;
    logic [CODE_W-1:0] code_c;
    logic              match_c;

    gate_classifier u_classifier (
        .tt      (tt_q),
        .code_c  (code_c),
        .match_c (match_c)
    );

    // Sweep FSM with registered operand and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            tt_q        <= '0;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            gate_code   <= GATE_UNKNOWN;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    if (start) begin
                        idx   <= '0;
                        cnt   <= '0;
                        tt_q  <= '0;
                        busy  <= 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Sample on the last held cycle of the current vector.
                    if (cnt == CNT_LAST) begin
                        tt_q[idx] <= y_in;
                        cnt       <= '0;
                        if (idx == IDX_LAST) begin
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                            state <= ST_CLASSIFY;
                        end else begin
                            idx            <= idx + IDX_W'(1);
                            {a_out, b_out} <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CLASSIFY: begin
                    truth_table <= tt_q;
                    gate_code   <= code_c;
                    match       <= match_c;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_analyzer.sv
// Closed-loop bench: each analyzer instance drives a selectable gate model
// whose output feeds back as y_in. Instances use S = 2, 1 and 5.
module tb_gate_truth_table_analyzer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         gate_sel = 0;
    logic       start_v [3];
    logic       y_v     [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [3:0] tt_v    [3];
    logic [2:0] code_v  [3];
    logic       match_v [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int         sel;
        logic [3:0] tt;
        logic [2:0] code;
        logic       match;
        string      name;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    // sel: 0..6 gate codes, 7 const one, 8 NOT_B, 9 B, 10 const zero
    function automatic logic model(input int sel, input logic a, input logic b);
        case (sel)
            0:       return a & b;
            1:       return a | b;
            2:       return ~a;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return a ^ b;
            6:       return ~(a ^ b);
            7:       return 1'b1;
            8:       return ~b;
            9:       return b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int s_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    assign y_v[0] = model(gate_sel, a_v[0], b_v[0]);
    assign y_v[1] = model(gate_sel, a_v[1], b_v[1]);
    assign y_v[2] = model(gate_sel, a_v[2], b_v[2]);

    gate_truth_table_analyzer #(.SETTLE_CYCLES(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y_v[0]),
        .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .truth_table(tt_v[0]), .gate_code(code_v[0]), .match(match_v[0])
    );

    gate_truth_table_analyzer #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y_v[1]),
        .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .truth_table(tt_v[1]), .gate_code(code_v[1]), .match(match_v[1])
    );

    gate_truth_table_analyzer #(.SETTLE_CYCLES(5)) dut_s5 (
        .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y_v[2]),
        .a_out(a_v[2]), .b_out(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .truth_table(tt_v[2]), .gate_code(code_v[2]), .match(match_v[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, " ab"},    int'({a_v[d], b_v[d]}), 0);
        chk({tag, " busy"},  int'(busy_v[d]), 0);
        chk({tag, " done"},  int'(done_v[d]), 0);
        chk({tag, " tt"},    int'(tt_v[d]), 0);
        chk({tag, " code"},  int'(code_v[d]), 7);
        chk({tag, " match"}, int'(match_v[d]), 0);
    endtask

    // One sweep; poke adds ignored start pulses while busy and in the done cycle.
    task automatic sweep(input int d, input int sel, input logic [3:0] etv,
                         input logic [2:0] ec, input logic em, input bit poke,
                         input string tag);
        int         s;
        int         lat;
        int         pulses;
        bit         ab_ok;
        bit         busy_ok;
        logic [1:0] exp_ab;
        s = s_of(d);
        @(negedge clk);
        gate_sel   = sel;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        lat     = 1;
        ab_ok   = 1'b1;
        busy_ok = 1'b1;
        while (!done_v[d] && lat < 200) begin
            exp_ab = (lat <= 4 * s) ? 2'((lat - 1) / s) : 2'b00;
            if ({a_v[d], b_v[d]} !== exp_ab) ab_ok = 1'b0;
            if (busy_v[d] !== 1'b1) busy_ok = 1'b0;
            start_v[d] = (poke && (lat == 3 || lat == 4 * s + 1)) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start_v[d] = 1'b0;
        chk({tag, " latency"},   lat, 4 * s + 2);
        chk({tag, " ab_seq"},    int'(ab_ok), 1);
        chk({tag, " busy_hi"},   int'(busy_ok), 1);
        chk({tag, " busy_done"}, int'(busy_v[d]), 0);
        chk({tag, " tt"},        int'(tt_v[d]), int'(etv));
        chk({tag, " code"},      int'(code_v[d]), int'(ec));
        chk({tag, " match"},     int'(match_v[d]), int'(em));
        if (poke) begin
            start_v[d] = 1'b1;
            @(negedge clk);
            start_v[d] = 1'b0;
            pulses = int'(done_v[d]);
            repeat (4 * s + 4) begin
                @(negedge clk);
                pulses += int'(done_v[d]) + int'(busy_v[d]);
            end
            chk({tag, " no_retrigger"}, pulses, 0);
        end else begin
            @(negedge clk);
            chk({tag, " done_pulse"}, int'(done_v[d]), 0);
        end
        chk({tag, " tt_hold"}, int'(tt_v[d]), int'(etv));
    endtask

    initial begin
        int pulses;
        vecs[0] = '{1,  4'b1110, 3'd1, 1'b1, "OR"};
        vecs[1] = '{2,  4'b0011, 3'd2, 1'b1, "NOT_A"};
        vecs[2] = '{3,  4'b0111, 3'd3, 1'b1, "NAND"};
        vecs[3] = '{4,  4'b0001, 3'd4, 1'b1, "NOR"};
        vecs[4] = '{7,  4'b1111, 3'd7, 1'b0, "ONE"};
        vecs[5] = '{8,  4'b0101, 3'd7, 1'b0, "NOT_B"};
        vecs[6] = '{9,  4'b1010, 3'd7, 1'b0, "B"};
        vecs[7] = '{10, 4'b0000, 3'd7, 1'b0, "ZERO"};
        vecs[8] = '{5,  4'b0110, 3'd5, 1'b1, "XOR"};
        vecs[9] = '{6,  4'b1001, 3'd6, 1'b1, "XNOR"};

        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0, "reset s2");
        chk_reset(1, "reset s1");
        chk_reset(2, "reset s5");
        rst = 1'b0;

        sweep(0, 0, 4'b1000, 3'd0, 1'b1, 1'b1, "AND s2");
        for (int i = 0; i < 10; i++)
            sweep(0, vecs[i].sel, vecs[i].tt, vecs[i].code, vecs[i].match, 1'b0, vecs[i].name);

        // Reset during cycle T+5 of an XOR sweep.
        @(negedge clk);
        gate_sel   = 5;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("midsweep busy", int'(busy_v[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0, "abort");
        sweep(0, 5, 4'b0110, 3'd5, 1'b1, 1'b0, "XOR after abort");

        sweep(1, 0, 4'b1000, 3'd0, 1'b1, 1'b0, "AND s1");
        sweep(2, 0, 4'b1000, 3'd0, 1'b1, 1'b0, "AND s5");
        sweep(2, 4, 4'b0001, 3'd4, 1'b1, 1'b0, "NOR s5");

        // Held start re-triggers from IDLE: S=1 gives a done every 7 cycles.
        @(negedge clk);
        gate_sel   = 1;
        start_v[1] = 1'b1;
        pulses = 0;
        repeat (16) begin
            @(negedge clk);
            pulses += int'(done_v[1]);
        end
        start_v[1] = 1'b0;
        chk("held start pulses", pulses, 2);
        chk("held start tt", int'(tt_v[1]), int'(4'b1110));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
